// File: rtl/param_stream_reader_if.sv
// Bus bundle for the parameter stream reader: the params-memory read port and the
// valid/ready word stream toward the compute datapath.
interface param_stream_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/param_stream_reader.sv
// Burst reader for the parameters memory: reads a contiguous range, absorbs the
// 1-cycle read latency and streams words in order through a 2-entry skid FIFO.
module param_stream_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     length,
    output logic                 busy,
    output logic                 done,
    param_stream_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic              inflight;
    logic              rd_en;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic [1:0]        count_next;
    logic              push;
    logic              pop;
    logic [2:0]        occupancy;

    assign push       = inflight;
    assign pop        = bus.out_valid & bus.out_ready;
    assign count_next = fifo_count + {1'b0, push} - {1'b0, pop};
    assign cur_addr   = base_q + ADDR_W'(issued);

    // Words buffered plus the one in flight, after this cycle's pop; the memory
    // cannot stall, so a read is only issued if its data is sure to have a slot.
    assign occupancy  = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                rd_en = (occupancy < 3'd2);
                if (rd_en && (issued == len_q - LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (count_next == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_en ? cur_addr : last_addr;
    assign bus.out_valid   = (fifo_count != 2'd0);
    assign bus.out_data    = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= rd_en;
            if (state == IDLE && start) begin
                base_q <= base_addr;
                len_q  <= length;
                issued <= '0;
            end
            if (rd_en) begin
                issued    <= issued + LEN_W'(1);
                last_addr <= cur_addr;
            end
        end
    end

    // Reset drops inflight, so data answering a pre-reset read is never pushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.mem_rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= count_next;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && fifo_count == 2'd2)
    );

    a_no_pop_when_empty: assert property (
        @(posedge clk) disable iff (!rst_n) !(pop && fifo_count == 2'd0)
    );

endmodule
